// File: rtl/nibble_add_seq.sv
// Sequential add/subtract that pushes one nibble per cycle through a single
// 4-bit carry-lookahead slice, with a valid/ready handshake on each side.
module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [IDXW-1:0]  idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic [3:0] a_nib, b_nib, s_nib, g, p;
    logic [4:0] c;

    // Shared slice operands: the selected nibble of each latched operand.
    assign a_nib = a_reg[{idx_reg, 2'b00} +: 4];
    assign b_nib = b_reg[{idx_reg, 2'b00} +: 4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pg
            assign g[gi]     = a_nib[gi] & b_nib[gi];
            assign p[gi]     = a_nib[gi] ^ b_nib[gi];
            assign s_nib[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Fully expanded lookahead carries; no carry ripples within the slice.
    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)       state_next = RUN;
            RUN:     if (idx_reg == LAST) state_next = DONE;
            DONE:    if (out_ready)      state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= op_sub ? ~b : b;
                        carry_reg <= op_sub;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    result_reg[{idx_reg, 2'b00} +: 4] <= s_nib;
                    carry_reg <= c[4];
                    if (idx_reg == LAST) begin
                        idx_reg       <= '0;
                        carry_out_reg <= c[4];
                        // On the top nibble the slice MSBs are the operand MSBs.
                        overflow_reg  <= (a_nib[3] == b_nib[3]) && (s_nib[3] != a_nib[3]);
                        zero_reg      <= (result_reg[WIDTH-5:0] == '0) && (s_nib == 4'h0);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: an arithmetic reference model plus a
// per-cycle compare process, pinned by hand-computed vectors.
module tb_nibble_add_seq;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             op_sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WIDTH-1:0] exp_result;
    logic             exp_carry, exp_ovf, exp_zero;
    bit               pending = 1'b0;
    int               accept_cyc = 0;
    bit               prev_valid = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs [8] = '{
        '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0},
        '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1},
        '{16'hABCD, 16'h1234, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0}
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic.
    task automatic model_op(input logic [15:0] x, input logic [15:0] y, input logic s);
        int sx = $signed(x);
        int sy = $signed(y);
        int ux = x;
        int uy = y;
        int r;
        r          = s ? (sx - sy) : (sx + sy);
        exp_ovf    = (r > 32767) || (r < -32768);
        exp_result = s ? (x - y) : (x + y);
        exp_carry  = s ? (ux >= uy) : ((ux + uy) > 65535);
        exp_zero   = (exp_result == 16'h0000);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (!prev_valid) begin
                    chk("valid_expected", 32'(pending), 32'd1);
                    chk("latency", 32'(cyc - accept_cyc), 32'(NIB));
                end
                chk("result", 32'(result), 32'(exp_result));
                chk("carry_out", 32'(carry_out), 32'(exp_carry));
                chk("overflow", 32'(overflow), 32'(exp_ovf));
                chk("zero", 32'(zero), 32'(exp_zero));
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
            end
            prev_valid <= out_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic start(input logic [15:0] x, input logic [15:0] y, input logic s);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a = x; b = y; op_sub = s; in_valid = 1'b1;
        model_op(x, y, s);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        pending    = 1'b1;
        // Scramble every request input while the operation runs.
        a = ~x ^ 16'h5A5A; b = y + 16'h1357; op_sub = ~s; in_valid = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        pending   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_carry_out"}, 32'(carry_out), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_zero"}, 32'(zero), 32'd0);
    endtask

    initial begin
        #1;
        chk_reset_outputs("por");
        chk("por_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_done();
            chk($sformatf("lit_result_%0d", i), 32'(result), 32'(vecs[i].r));
            chk($sformatf("lit_carry_%0d", i), 32'(carry_out), 32'(vecs[i].c));
            chk($sformatf("lit_ovf_%0d", i), 32'(overflow), 32'(vecs[i].v));
            chk($sformatf("lit_zero_%0d", i), 32'(zero), 32'(vecs[i].z));
            chk($sformatf("model_result_%0d", i), 32'(exp_result), 32'(vecs[i].r));
            chk($sformatf("model_flags_%0d", i), 32'({exp_carry, exp_ovf, exp_zero}),
                32'({vecs[i].c, vecs[i].v, vecs[i].z}));
            if (i == 0) begin
                for (int k = 0; k < 3; k++) begin
                    in_valid = ~in_valid;
                    a = 16'($urandom);
                    b = 16'($urandom);
                    @(negedge clk);
                    chk($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
                    chk($sformatf("bp_result_%0d", k), 32'(result), 32'h2201);
                end
                in_valid = 1'b1;
            end
            $display("op %0d: a=%04h b=%04h sub=%0d -> result=%04h c=%0d v=%0d z=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].op, result, carry_out, overflow, zero);
            finish_op();
        end

        // Reset in the middle of an operation.
        start(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        pending  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_held_valid", 32'(out_valid), 32'd0);
        chk("rst_held_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        start(16'h0001, 16'h0001, 1'b0);
        wait_done();
        chk("post_rst_result", 32'(result), 32'h0002);
        $display("op post-reset: a=0001 b=0001 sub=0 -> result=%04h c=%0d v=%0d z=%0d",
                 result, carry_out, overflow, zero);
        finish_op();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits; SHALL be a multiple of 4 and at least 8; NIB = WIDTH/4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op_sub  input  1  0 = a+b, 1 = a-b; sampled at accept.
REQ-007 a  input  WIDTH  first operand; sampled at accept.
REQ-008 b  input  WIDTH  second operand; sampled at accept.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 carry_out  output  1  final carry; for subtract, 1 = no borrow.
REQ-013 overflow  output  1  two's-complement overflow.
REQ-014 zero  output  1  result == 0.

Function
REQ-015 The block SHALL contain exactly one 4-bit carry-lookahead adder slice (a_nib, b_nib, cin -> s_nib, cout), shared across all nibbles.
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1 and out_valid=0; accept occurs when in_valid && in_ready at a rising edge.
REQ-018 On accept: latch a; latch b (b inverted when op_sub=1); latch op_sub; set carry register to op_sub; set nibble index to 0; go to RUN.
REQ-019 RUN: in_ready=0 and out_valid=0; each cycle the slice SHALL add latched nibble[idx] of a and of b-or-~b with the carry register.
REQ-020 RUN, each edge: store s_nib into result[4*idx+3:4*idx]; store cout into the carry register; increment idx.
REQ-021 RUN, edge with idx==NIB-1: perform the REQ-020 store; load carry_out with cout; go to DONE.
REQ-022 Latency: out_valid SHALL rise exactly NIB rising edges after the accepting edge (4 for WIDTH=16).
REQ-023 overflow SHALL be 1 when the MSB of a equals the MSB of the effective b and differs from the result MSB; it SHALL be registered when entering DONE.
REQ-024 zero SHALL be registered when entering DONE.
REQ-025 DONE: out_valid=1 and in_ready=0; result and all flags SHALL stay stable until out_ready=1.
REQ-026 DONE with out_ready=1 at an edge: go to IDLE, with out_valid=0 from the next cycle; no back-to-back accept occurs in that same cycle.
REQ-027 in_valid, a, b and op_sub SHALL be ignored outside IDLE; changes to them during RUN SHALL NOT affect the result.
REQ-028 The nibble index SHALL be ceil(log2(NIB)) bits wide, with no wrap-around beyond NIB-1.
REQ-029 Result bits not yet written during RUN are don't-care, because out_valid=0.

Reset
REQ-030 When rst_n=0, at any time including mid-RUN: state=IDLE; idx=0; carry register=0; result=0; carry_out=0; overflow=0; zero=0; out_valid=0; in_ready=1 once rst_n=1.
REQ-031 An operation interrupted by reset SHALL be discarded; it produces no out_valid.
REQ-032 The first accept after reset deassertion SHALL be allowed on the first rising edge.

Verification
REQ-033 Add 0x1234+0x0FCD -> after 4 edges: result=0x2201, carry_out=0, overflow=0, zero=0.
REQ-034 Add 0xFFFF+0x0001 -> result=0x0000, carry_out=1, zero=1, overflow=0; then add 0x7FFF+0x0001 -> result=0x8000, overflow=1, carry_out=0.
REQ-035 Subtract 0x0005-0x0007 -> result=0xFFFE, carry_out=0 (borrow), overflow=0; subtract 0x8000-0x0001 -> result=0x7FFF, overflow=1, carry_out=1.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid, a and b -> out_valid stays 1, outputs stay stable, in_ready stays 0, no new accept; with out_ready=1 -> IDLE the next cycle.
REQ-037 Deassert rst_n after 2 RUN cycles -> all outputs are immediately at their reset values and no out_valid follows; a new request 0x0001+0x0001 completes with result=0x0002.
REQ-038 Change a and b during RUN -> result matches the operands latched at accept.
